// File: rtl/uart_pkg.sv
// uart_pkg -- shared UART definitions.
//   uart_rx_sm_t        : receiver state encoding (4-bit)
//   UART_DEFAULT_CLK_HZ : default clock frequency in Hz
//   UART_DEFAULT_BAUD   : default line bit rate
//   maj3()              : 2-of-3 majority vote helper
package uart_pkg;

  localparam int unsigned UART_DEFAULT_CLK_HZ = 79_500_000;
  localparam int unsigned UART_DEFAULT_BAUD   = 115_200;

  typedef enum logic [3:0] {
    SM_IDLE      = 4'd0,
    SM_START     = 4'd1,
    SM_DATA      = 4'd2,
    SM_STOP      = 4'd3,
    SM_WAIT_HIGH = 4'd4
  } uart_rx_sm_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer -- free-running bit-period timer, 0..P_BIT-1 then wraps.
//   clk     : clock, rising edge
//   i_nrst  : asynchronous active-low reset (timer -> 0)
//   i_clear : force the timer to 0 on the next edge
//   o_half  : timer == P_HALF-1 (mid start bit)
//   o_term  : timer == P_BIT-1 (bit period elapsed)
module uart_bit_timer #(
  parameter int unsigned P_BIT  = 690,
  parameter int unsigned P_HALF = 345
) (
  input  logic clk,
  input  logic i_nrst,
  input  logic i_clear,
  output logic o_half,
  output logic o_term
);

  localparam int unsigned W = $clog2(P_BIT);
  localparam logic [W-1:0] LAST_CNT = W'(P_BIT - 1);
  localparam logic [W-1:0] HALF_CNT = W'(P_HALF - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    o_half = (cnt_q == HALF_CNT);
    o_term = (cnt_q == LAST_CNT);
    cnt_d  = cnt_q + W'(1);
    if (i_clear || o_term) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx -- 8N1 UART byte receiver with valid/ready output.
//   clk         : clock, rising edge
//   i_nrst      : asynchronous active-low reset
//   i_uart_rx   : asynchronous serial line, idle high
//   o_data      : last received byte
//   o_valid     : o_data holds an unconsumed byte
//   i_ready     : consumer accepts o_data when o_valid is 1
//   o_frame_err : one-cycle pulse when the stop bit is sampled low
//   o_overrun   : one-cycle pulse when a completed byte is dropped
// Build option: define UART_RX_MAJORITY_EN to take every sample as the
// 2-of-3 majority of the line over the sample cycle and the two before it.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned P_CLK_HZ = UART_DEFAULT_CLK_HZ,
  parameter int unsigned P_BAUD   = UART_DEFAULT_BAUD
) (
  input  logic       clk,
  input  logic       i_nrst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int unsigned P_BIT  = P_CLK_HZ / P_BAUD;
  localparam int unsigned P_HALF = P_BIT / 2;

  uart_rx_sm_t state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        sync1_q, sync2_q;
  logic        line;
  logic        sample;
  logic        tmr_clear;
  logic        tmr_half;
  logic        tmr_term;
  logic        byte_done;

  // Two-flop synchronizer, idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_uart_rx;
      sync2_q <= sync1_q;
    end
  end

  always_comb line = sync2_q;

`ifdef UART_RX_MAJORITY_EN
  logic hist1_q, hist2_q;

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
    end else begin
      hist1_q <= line;
      hist2_q <= hist1_q;
    end
  end

  always_comb sample = maj3(line, hist1_q, hist2_q);
`else
  always_comb sample = line;
`endif

  uart_bit_timer #(
    .P_BIT  (P_BIT),
    .P_HALF (P_HALF)
  ) u_bit_timer (
    .clk     (clk),
    .i_nrst  (i_nrst),
    .i_clear (tmr_clear),
    .o_half  (tmr_half),
    .o_term  (tmr_term)
  );

  // Next-state / datapath
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    tmr_clear = 1'b0;
    byte_done = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      SM_IDLE: begin
        tmr_clear = 1'b1;
        if (!line) begin
          state_d = SM_START;
        end
      end
      SM_START: begin
        if (tmr_half) begin
          tmr_clear = 1'b1;
          if (sample) begin
            state_d = SM_IDLE;
          end else begin
            state_d  = SM_DATA;
            bitcnt_d = '0;
          end
        end
      end
      SM_DATA: begin
        if (tmr_term) begin
          shift_d  = {sample, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = SM_STOP;
          end
        end
      end
      SM_STOP: begin
        if (tmr_term) begin
          if (sample) begin
            byte_done = 1'b1;
            state_d   = SM_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = SM_WAIT_HIGH;
          end
        end
      end
      SM_WAIT_HIGH: begin
        tmr_clear = 1'b1;
        if (line) begin
          state_d = SM_IDLE;
        end
      end
      default: begin
        tmr_clear = 1'b1;
        state_d   = SM_IDLE;
      end
    endcase
  end

  // Output handshake: a completed byte replaces o_data only if the slot is
  // empty or being consumed this very cycle; otherwise it is dropped.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
    if (byte_done) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q  <= SM_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    o_data      = data_q;
    o_valid     = valid_q;
    o_frame_err = ferr_q;
    o_overrun   = ovr_q;
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx -- scoreboard bench for uart_byte_rx at 690 cycles/bit.
// Stimulus pushes expected bytes into a queue; a negedge monitor pops and
// compares on every accepted byte and counts error pulses.
module tb_uart_byte_rx;

  localparam int unsigned CLK_HZ = 79_500_000;
  localparam int unsigned BAUD   = 115_200;
  localparam int BIT  = CLK_HZ / BAUD;
  localparam int HALF = BIT / 2;

  logic       clk = 1'b0;
  logic       i_nrst = 1'b0;
  logic       i_uart_rx = 1'b1;
  logic       i_ready = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;

  int checks = 0;
  int errors = 0;
  int vld_cycles = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic ferr_prev = 1'b0;
  logic ovr_prev = 1'b0;
  logic [7:0] exp_q[$];

  uart_byte_rx #(
    .P_CLK_HZ (CLK_HZ),
    .P_BAUD   (BAUD)
  ) dut (
    .clk         (clk),
    .i_nrst      (i_nrst),
    .i_uart_rx   (i_uart_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame, one value per clock. Optional 1-cycle high glitch
  // at the middle of every data bit, and optional reset pulse at cycle rst_at.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input bit glitch, input int rst_at);
    int   bi;
    logic v;
    for (int c = 0; c < 10 * BIT; c++) begin
      bi = c / BIT;
      if (bi == 0) v = 1'b0;
      else if (bi <= 8) v = b[bi-1];
      else v = stop_bit;
      if (glitch && bi >= 1 && bi <= 8 && c == BIT * bi + HALF) v = 1'b1;
      if (c == rst_at) i_nrst = 1'b0;
      if (c == rst_at + 5) i_nrst = 1'b1;
      if (c == rst_at + 1) begin
        check("mid_reset_valid", int'(o_valid), 0);
        check("mid_reset_data", int'(o_data), 0);
      end
      i_uart_rx = v;
      @(posedge clk);
      #1;
    end
    i_uart_rx = 1'b1;
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (i_nrst) begin
        if (o_valid) vld_cycles++;
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got 0x%0h expected none", o_data);
          end else begin
            check("rx_byte", int'(o_data), int'(exp_q.pop_front()));
          end
        end
        if (o_frame_err) begin
          ferr_cnt++;
          check("frame_err_width", int'(ferr_prev), 0);
        end
        if (o_overrun) begin
          ovr_cnt++;
          check("overrun_width", int'(ovr_prev), 0);
        end
        ferr_prev = o_frame_err;
        ovr_prev  = o_overrun;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    idle(4);
    check("reset_valid", int'(o_valid), 0);
    check("reset_data", int'(o_data), 0);
    check("reset_ferr", int'(o_frame_err), 0);
    check("reset_ovr", int'(o_overrun), 0);
    i_nrst = 1'b1;
    idle(10);

    // 0x55, consumer always ready
    v0 = vld_cycles;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0, -100);
    idle(20);
    check("b55_valid_cycles", vld_cycles - v0, 1);
    check("b55_queue", exp_q.size(), 0);
    check("b55_ferr", ferr_cnt, 0);
    check("b55_ovr", ovr_cnt, 0);

    // 100-cycle low glitch: false start
    v0 = vld_cycles;
    i_uart_rx = 1'b0;
    idle(100);
    i_uart_rx = 1'b1;
    idle(1000);
    check("glitch_valid_cycles", vld_cycles - v0, 0);
    check("glitch_valid", int'(o_valid), 0);

    // 0xA3 with stop bit low, then 0x0F
    v0 = vld_cycles;
    send_frame(8'hA3, 1'b0, 1'b0, -100);
    idle(20);
    check("a3_ferr", ferr_cnt, 1);
    check("a3_valid_cycles", vld_cycles - v0, 0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 1'b0, -100);
    idle(20);
    check("b0f_queue", exp_q.size(), 0);
    check("b0f_ferr", ferr_cnt, 1);

    // 0x12 then 0x34 with consumer stalled
    i_ready = 1'b0;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0, -100);
    send_frame(8'h34, 1'b1, 1'b0, -100);
    idle(20);
    check("ovr_valid_held", int'(o_valid), 1);
    check("ovr_data_kept", int'(o_data), 'h12);
    check("ovr_count", ovr_cnt, 1);
    i_ready = 1'b1;
    idle(1);
    check("ovr_valid_cleared", int'(o_valid), 0);
    check("ovr_queue", exp_q.size(), 0);

    // reset mid-DATA of 0xFF, then 0x81
    v0 = vld_cycles;
    send_frame(8'hFF, 1'b1, 1'b0, 4 * BIT);
    idle(20);
    check("rst_no_byte", vld_cycles - v0, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0, -100);
    idle(20);
    check("b81_queue", exp_q.size(), 0);
    check("b81_valid_cycles", vld_cycles - v0, 1);

    // 0x00 with a high glitch on every data sample point
`ifdef UART_RX_MAJORITY_EN
    exp_q.push_back(8'h00);
`else
    exp_q.push_back(8'hFF);
`endif
    send_frame(8'h00, 1'b1, 1'b1, -100);
    idle(20);
    check("maj_queue", exp_q.size(), 0);
    check("final_ferr", ferr_cnt, 1);
    check("final_ovr", ovr_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
